// File: rtl/latch_drv_pkg.sv
// Shared types and helpers for the latch gate driver and its phase timer.
package latch_drv_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} latch_drv_state_t;

  // Counter width large enough to hold the longest phase length.
  function automatic int cnt_width(input int s, input int g, input int h);
    int m;
    m = s;
    if (g > m) m = g;
    if (h > m) m = h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/latch_drv_timer.sv
// Loadable phase down-counter; tc marks the last cycle of the current phase.
module latch_drv_timer
  import latch_drv_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts down to zero and parks there until the next phase load.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(1));

endmodule

// File: rtl/latch_gate_driver.sv
// Write-side driver for a transparent latch bank: setup, gate and hold windows.
// Optional readback compare is enabled by defining LATCH_DRV_READBACK_EN.
module latch_gate_driver
  import latch_drv_pkg::*;
#(
  parameter int W         = 4,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] lat_d,
  output logic         lat_en,
`ifdef LATCH_DRV_READBACK_EN
  input  logic [W-1:0] lat_q,
  output logic         mismatch,
`endif
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(SETUP_CYC, GATE_CYC, HOLD_CYC);

  latch_drv_state_t state_q, state_d;
  logic [W-1:0]     latD_q, latD_d;
  logic             latEn_q, latEn_d;
  logic             done_q, done_d;
  logic             accept;
  logic             timerLoad;
  logic [CW-1:0]    timerVal;
  logic             tc;

  latch_drv_timer #(
    .CW(CW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timerLoad),
    .load_val(timerVal),
    .tc      (tc)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = !in_ready;
  assign accept   = in_valid && in_ready;

  // Phase sequencing; lat_en and lat_d only change at phase boundaries.
  always_comb begin
    state_d   = state_q;
    latD_d    = latD_q;
    latEn_d   = latEn_q;
    done_d    = 1'b0;
    timerLoad = 1'b0;
    timerVal  = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          latD_d    = in_data;
          state_d   = SETUP;
          timerLoad = 1'b1;
          timerVal  = CW'(SETUP_CYC);
        end
      end
      SETUP: begin
        if (tc) begin
          state_d   = OPEN;
          latEn_d   = 1'b1;
          timerLoad = 1'b1;
          timerVal  = CW'(GATE_CYC);
        end
      end
      OPEN: begin
        if (tc) begin
          state_d   = HOLD;
          latEn_d   = 1'b0;
          timerLoad = 1'b1;
          timerVal  = CW'(HOLD_CYC);
        end
      end
      HOLD: begin
        if (tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        latEn_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      latD_q  <= '0;
      latEn_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      latD_q  <= latD_d;
      latEn_q <= latEn_d;
      done_q  <= done_d;
    end
  end

  assign lat_d  = latD_q;
  assign lat_en = latEn_q;
  assign done   = done_q;

`ifdef LATCH_DRV_READBACK_EN
  logic holdFirst_q;
  logic sampErr_q;
  logic mismatch_q;
  logic cmpErr;

  assign cmpErr = (lat_q != latD_q);

  // Readback is taken in the first HOLD cycle; a one-cycle HOLD compares live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdFirst_q <= 1'b0;
      sampErr_q   <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      holdFirst_q <= (state_q == OPEN) && tc;
      if (holdFirst_q) begin
        sampErr_q <= cmpErr;
      end
      if (accept) begin
        mismatch_q <= 1'b0;
      end else if ((state_q == HOLD) && tc && (holdFirst_q ? cmpErr : sampErr_q)) begin
        mismatch_q <= 1'b1;
      end
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_latch_gate_driver.sv
// Directed self-checking bench for latch_gate_driver (default and 3/1/2 timing).
// Readback scenario runs only when LATCH_DRV_READBACK_EN is defined.
module tb_latch_gate_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inValid, inReady, latEn, busy, done;
  logic [3:0] inData, latD;
  logic       inValid2, inReady2, latEn2, busy2, done2;
  logic [3:0] inData2, latD2;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

`ifdef LATCH_DRV_READBACK_EN
  logic [3:0] latchQ = 4'h0;
  logic [3:0] latQ;
  logic       forceZero = 1'b0;
  logic       mismatch, mismatch2;

  always_latch begin
    if (latEn) latchQ <= latD;
  end
  assign latQ = forceZero ? 4'h0 : latchQ;
`endif

  latch_gate_driver #(.W(4), .SETUP_CYC(1), .GATE_CYC(2), .HOLD_CYC(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(inValid),
    .in_ready(inReady),
    .in_data (inData),
    .lat_d   (latD),
    .lat_en  (latEn),
`ifdef LATCH_DRV_READBACK_EN
    .lat_q   (latQ),
    .mismatch(mismatch),
`endif
    .busy    (busy),
    .done    (done)
  );

  latch_gate_driver #(.W(4), .SETUP_CYC(3), .GATE_CYC(1), .HOLD_CYC(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(inValid2),
    .in_ready(inReady2),
    .in_data (inData2),
    .lat_d   (latD2),
    .lat_en  (latEn2),
`ifdef LATCH_DRV_READBACK_EN
    .lat_q   (latD2),
    .mismatch(mismatch2),
`endif
    .busy    (busy2),
    .done    (done2)
  );

  // Expected outputs k cycles after the accept edge, from the phase lengths.
  function automatic logic expEn(int k, int s, int g);
    return (k >= s) && (k < s + g);
  endfunction

  function automatic logic expReady(int k, int s, int g, int h);
    return k >= s + g + h;
  endfunction

  function automatic logic expDone(int k, int s, int g, int h);
    return k == s + g + h;
  endfunction

  task automatic test_reset();
    inValid = 1'b0; inData = 4'h0; inValid2 = 1'b0; inData2 = 4'h0;
    rst_n = 1'b0;
    #12;
    total++;
    if (latEn !== 1'b0 || latD !== 4'h0 || inReady !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold en=%b d=%h rdy=%b done=%b want 0 0 1 0", latEn, latD, inReady, done);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (latEn !== 1'b0 || latD !== 4'h0 || inReady !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_idle c=%0d en=%b d=%h rdy=%b done=%b busy=%b want 0 0 1 0 0",
                 c, latEn, latD, inReady, done, busy);
      end
    end
  endtask

  task automatic test_single();
    @(negedge clk); inValid = 1'b1; inData = 4'hA;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) begin inValid = 1'b0; inData = 4'h0; end
      total++;
      if (latD !== 4'hA || latEn !== expEn(k, 1, 2) || inReady !== expReady(k, 1, 2, 1) ||
          done !== expDone(k, 1, 2, 1) || busy !== !expReady(k, 1, 2, 1)) begin
        bad++;
        $display("[TB] FAIL single k=%0d d=%h en=%b rdy=%b done=%b busy=%b want A %b %b %b %b", k, latD, latEn,
                 inReady, done, busy, expEn(k, 1, 2), expReady(k, 1, 2, 1), expDone(k, 1, 2, 1),
                 !expReady(k, 1, 2, 1));
      end
    end
  endtask

  // Valid held high: next accept lands in the done cycle, so the period is 5.
  task automatic test_stream();
    logic [3:0] wantD;
    int         j;
    @(negedge clk); inValid = 1'b1; inData = 4'hA;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k == 0) inData = 4'h5;
      if (k == 5) inData = 4'hF;
      if (k == 10) inValid = 1'b0;
      wantD = (k < 5) ? 4'hA : (k < 10) ? 4'h5 : 4'hF;
      j = k % 5;
      total++;
      if (k == 15) begin
        if (latD !== 4'hF || latEn !== 1'b0 || inReady !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("[TB] FAIL stream_end d=%h en=%b rdy=%b done=%b want F 0 1 0", latD, latEn, inReady, done);
        end
      end else if (latD !== wantD || latEn !== expEn(j, 1, 2) || done !== expDone(j, 1, 2, 1) ||
                   inReady !== expReady(j, 1, 2, 1)) begin
        bad++;
        $display("[TB] FAIL stream k=%0d d=%h en=%b done=%b rdy=%b want %h %b %b %b", k, latD, latEn, done,
                 inReady, wantD, expEn(j, 1, 2), expDone(j, 1, 2, 1), expReady(j, 1, 2, 1));
      end
    end
  endtask

  task automatic test_toggle();
    @(negedge clk); inValid = 1'b1; inData = 4'h6;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 3) inData = ~inData;
      if (k == 3) inValid = 1'b0;
      total++;
      if (latD !== 4'h6 || done !== expDone(k, 1, 2, 1)) begin
        bad++;
        $display("[TB] FAIL toggle k=%0d d=%h done=%b want 6 %b", k, latD, done, expDone(k, 1, 2, 1));
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); inValid = 1'b1; inData = 4'hC;
    @(negedge clk); inValid = 1'b0;
    @(negedge clk);
    total++;
    if (latEn !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_open en=%b want 1", latEn);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (latEn !== 1'b0 || latD !== 4'h0 || inReady !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_async en=%b d=%h rdy=%b done=%b want 0 0 1 0", latEn, latD, inReady, done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || inReady !== 1'b1 || latEn !== 1'b0) begin
        bad++;
        $display("[TB] FAIL mid_after c=%0d done=%b rdy=%b en=%b want 0 1 0", c, done, inReady, latEn);
      end
    end
  endtask

`ifdef LATCH_DRV_READBACK_EN
  task automatic test_readback();
    logic wantM;
    forceZero = 1'b0;
    @(negedge clk); inValid = 1'b1; inData = 4'h3;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) inValid = 1'b0;
      total++;
      if (mismatch !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rb_good k=%0d mismatch=%b want 0", k, mismatch);
      end
    end
    forceZero = 1'b1;
    @(negedge clk); inValid = 1'b1; inData = 4'h3;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) inValid = 1'b0;
      wantM = (k >= 4);
      total++;
      if (mismatch !== wantM) begin
        bad++;
        $display("[TB] FAIL rb_bad k=%0d mismatch=%b want %b", k, mismatch, wantM);
      end
    end
    forceZero = 1'b0;
    inValid = 1'b1; inData = 4'h3;
    @(negedge clk); inValid = 1'b0;
    total++;
    if (mismatch !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rb_clear mismatch=%b want 0", mismatch);
    end
    repeat (5) @(negedge clk);
  endtask
`endif

  task automatic test_params();
    @(negedge clk); inValid2 = 1'b1; inData2 = 4'hB;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) inValid2 = 1'b0;
      total++;
      if (latD2 !== 4'hB || latEn2 !== expEn(k, 3, 1) || done2 !== expDone(k, 3, 1, 2) ||
          inReady2 !== expReady(k, 3, 1, 2) || busy2 !== !expReady(k, 3, 1, 2)) begin
        bad++;
        $display("[TB] FAIL params k=%0d d=%h en=%b done=%b rdy=%b busy=%b want B %b %b %b %b", k, latD2,
                 latEn2, done2, inReady2, busy2, expEn(k, 3, 1), expDone(k, 3, 1, 2), expReady(k, 3, 1, 2),
                 !expReady(k, 3, 1, 2));
      end
`ifdef LATCH_DRV_READBACK_EN
      total++;
      if (mismatch2 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL params_rb k=%0d mismatch=%b want 0", k, mismatch2);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_toggle();
    test_reset_mid();
`ifdef LATCH_DRV_READBACK_EN
    test_readback();
`endif
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
